// File: rtl/if_stage.sv
// Instruction-fetch stage: synchronous instruction memory whose registered read port
// is the IF/ID pipeline latch, plus PC+1 generation and a saturating fetch counter.
module if_stage #(
    parameter int                 ADDR_W = 11,
    parameter int                 DATA_W = 32,
    parameter int                 DEPTH  = 2048,
    parameter logic [DATA_W-1:0]  NOP    = '0,
    parameter int                 CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [DATA_W-1:0] imem_wdata,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc_plus1,
    output logic              if_id_valid,
    output logic [CNT_W-1:0]  fetch_count
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] instr_reg;
    logic [ADDR_W-1:0] pc_plus1_reg;
    logic              valid_reg;
    logic [CNT_W-1:0]  count_reg;

    // Natural ADDR_W-bit wrap gives 2**ADDR_W-1 -> 0.
    assign pc_plus1 = pc_in + ADDR_W'(1);

    // Program-image write port; a write coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (imem_we && !reset) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    // IF/ID latch doubles as the memory read register, so reads see pre-write data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_reg    <= NOP;
            pc_plus1_reg <= '0;
            valid_reg    <= 1'b0;
        end else if (flush) begin
            instr_reg    <= NOP;
            pc_plus1_reg <= pc_plus1;
            valid_reg    <= 1'b0;
        end else if (!stall) begin
            instr_reg    <= mem[pc_in];
            pc_plus1_reg <= pc_plus1;
            valid_reg    <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (!flush && !stall && !(&count_reg)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign if_id_instr    = instr_reg;
    assign if_id_pc_plus1 = pc_plus1_reg;
    assign if_id_valid    = valid_reg;
    assign fetch_count    = count_reg;

endmodule
